// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register bank.
// FSM states, index/counter sizing and completion status codes.
package apb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    localparam logic APB_OK  = 1'b0;
    localparam logic APB_ERR = 1'b1;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// Register storage: reg0 is a fixed ID word, regs 1..N-1 are writable.
// One write port, one combinational read port, flat register image.
module apb_regfile #(
    parameter int                DATA_W   = 32,
    parameter int                NUM_REGS = 16,
    parameter int                IDX_W    = 4,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'hA0B1_0001
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [IDX_W-1:0]           idx,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    logic [DATA_W-1:0] mem [1:NUM_REGS-1];
    logic              idx_ok;

    assign idx_ok = (idx != '0) && (int'(idx) < NUM_REGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && idx_ok) begin
            mem[idx] <= wdata;
        end
    end

    always_comb begin
        rdata = ID_VALUE;
        if (idx_ok) begin
            rdata = mem[idx];
        end
    end

    always_comb begin
        regs_o = '0;
        regs_o[0 +: DATA_W] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_o[i*DATA_W +: DATA_W] = mem[i];
        end
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 completer with programmable wait states and decode-error reporting.
// Holds the transfer FSM; storage lives in apb_regfile.
module apb_slave_regbank #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                NUM_REGS    = 16,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA0B1_0001
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [ADDR_W-1:0]          PADDR,
    input  logic [DATA_W-1:0]          PWDATA,
    output logic [DATA_W-1:0]          PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);
    import apb_pkg::*;

    localparam int IDX_W = idx_w(NUM_REGS);
    localparam int CNT_W = cnt_w(WAIT_CYCLES);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              wr_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-3:0] word;
    logic              dec_err;
    logic              ready;
    logic              we;

    // Full word address is compared so aliases above the bank are rejected.
    assign word    = PADDR[ADDR_W-1:2];
    assign dec_err = (PADDR[1:0] != 2'b00)
                  || (word >= (ADDR_W-2)'(NUM_REGS))
                  || (PWRITE && (word == '0));

    assign ready   = (state == ST_ACCESS) && (cnt == '0) && PSEL && PENABLE;
    assign we      = ready && !err_q && wr_q;
    assign PREADY  = ready;
    assign PSLVERR = ready && err_q;
    assign PRDATA  = (ready && !err_q && !wr_q) ? rd_data : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= APB_OK;
            wdata_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (PSEL) begin
                        state   <= ST_ACCESS;
                        wr_q    <= PWRITE;
                        idx_q   <= PADDR[IDX_W+1:2];
                        wdata_q <= PWDATA;
                        if (!PENABLE) begin
                            err_q <= dec_err ? APB_ERR : APB_OK;
                            cnt   <= CNT_W'(WAIT_CYCLES);
                        end else begin
                            err_q <= APB_ERR;
                            cnt   <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        state <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (PENABLE) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    apb_regfile #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .IDX_W   (IDX_W),
        .ID_VALUE(ID_VALUE)
    ) u_regfile (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (we),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (rd_data),
        .regs_o(regs_o)
    );

endmodule
